// File: rtl/async_fifo_pkg.sv
// async_fifo_pkg: default geometry shared by the FIFO control logic and its storage.
// Rev 1.0
`default_nettype none

package async_fifo_pkg;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int PTR_WIDTH_DEF  = ADDR_WIDTH_DEF + 1;
endpackage

`default_nettype wire

// File: rtl/async_fifo_mem.sv
// async_fifo_mem: 2^ADDR_WIDTH x DATA_WIDTH storage, one synchronous write port and one registered read port.
// Rev 1.0
`default_nettype none

module async_fifo_mem
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // The array itself carries no reset; only the read register is cleared.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;
endmodule

`default_nettype wire

// File: rtl/async_fifo.sv
// async_fifo: single-clock FIFO with binary wrap-bit pointers and registered read data.
// Optional ASYNC_FIFO_ERR_FLAGS_EN adds sticky overflow/underflow outputs. Rev 1.0
`default_nettype none

module async_fifo
  import async_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] wrdata,
  input  logic                  wren,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] rddata,
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  output logic                  overflow,
  output logic                  underflow,
`endif
  output logic                  full,
  output logic                  empty
);
  localparam int               PTR_W   = ADDR_WIDTH + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             wr_acc, rd_acc;

  // Flags come straight from the registered pointers, so they track each edge.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]) &&
                 (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]);

  assign wr_acc = wren && !full && !rst;
  assign rd_acc = rden && !empty && !rst;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic overflow_q, underflow_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wren && full)  overflow_q  <= 1'b1;
      if (rden && empty) underflow_q <= 1'b1;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

  async_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .rst     (rst),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (wrdata),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q[ADDR_WIDTH-1:0]),
    .rdata_o (rddata)
  );
endmodule

`default_nettype wire

// File: tb/tb_async_fifo.sv
// tb_async_fifo: directed self-checking bench for async_fifo.
// Rev 1.0
`default_nettype none

module tb_async_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] wrdata = 8'h00;
  logic       wren = 1'b0;
  logic       rden = 1'b0;
  logic [7:0] rddata;
  logic       full, empty;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
  logic       overflow, underflow;
`endif

  int n_vec = 0;
  int n_err = 0;

  async_fifo #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .wrdata    (wrdata),
    .wren      (wren),
    .rden      (rden),
    .rddata    (rddata),
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    .overflow  (overflow),
    .underflow (underflow),
`endif
    .full      (full),
    .empty     (empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] d);
    wren = 1'b1; wrdata = d;
    step();
    wren = 1'b0;
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    rden = 1'b1;
    step();
    rden = 1'b0;
    chk(tag, rddata, exp);
  endtask

  logic [7:0] seq4 [4] = '{8'hA8, 8'h08, 8'h68, 8'h54};

  initial begin
    #10;
    step();
    rst = 1'b0;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rddata", rddata, 8'h00);

    for (int i = 0; i < 4; i++) push(seq4[i]);
    chk("seq_notempty", empty, 0);
    for (int i = 0; i < 4; i++) pop("seq_rd", seq4[i]);
    chk("seq_empty", empty, 1);

    for (int i = 0; i < 16; i++) begin
      push(8'(i));
      if (i == 14) chk("fill15_notfull", full, 0);
    end
    chk("fill16_full", full, 1);
    push(8'hFF);
    chk("ovf_full", full, 1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("ovf_flag", overflow, 1);
`endif
    for (int i = 0; i < 16; i++) pop("full_rd", 8'(i));
    chk("drain_empty", empty, 1);

    rden = 1'b1; step(); rden = 1'b0;
    chk("udf_hold", rddata, 8'h0F);
    chk("udf_empty", empty, 1);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("udf_flag", underflow, 1);
`endif
    push(8'h5A);
    pop("udf_ptr", 8'h5A);

    for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
    wren = 1'b1; rden = 1'b1; wrdata = 8'hEE;
    step();
    wren = 1'b0; rden = 1'b0;
    chk("fullrw_rd", rddata, 8'h10);
    chk("fullrw_full", full, 0);
    for (int i = 1; i < 16; i++) pop("fullrw_drain", 8'h10 + 8'(i));
    chk("fullrw_noEE", empty, 1);

    wren = 1'b1; rden = 1'b1; wrdata = 8'h77;
    step();
    wren = 1'b0; rden = 1'b0;
    chk("emptyrw_hold", rddata, 8'h1F);
    chk("emptyrw_wr", empty, 0);
    pop("emptyrw_rd", 8'h77);

    push(8'h01); push(8'h02);
    wren = 1'b1; rden = 1'b1; wrdata = 8'h03;
    step();
    wren = 1'b0; rden = 1'b0;
    chk("midrw_rd", rddata, 8'h01);
    pop("midrw_2", 8'h02);
    pop("midrw_3", 8'h03);
    chk("midrw_empty", empty, 1);

    for (int i = 0; i < 10; i++) push(8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) pop("wrap_a", 8'h30 + 8'(i));
    for (int i = 0; i < 10; i++) push(8'h50 + 8'(i));
    for (int i = 0; i < 10; i++) pop("wrap_b", 8'h50 + 8'(i));
    chk("wrap_empty", empty, 1);

    push(8'hC1); push(8'hC2); push(8'hC3);
    rst = 1'b1; step(); rst = 1'b0;
    chk("mrst_empty", empty, 1);
    chk("mrst_full", full, 0);
    chk("mrst_rddata", rddata, 8'h00);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    chk("mrst_ovf", overflow, 0);
    chk("mrst_udf", underflow, 0);
`endif
    push(8'h99);
    pop("mrst_rd", 8'h99);
    chk("mrst_end_empty", empty, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

`default_nettype wire
